// File: rtl/coin_pkg.sv
// Shared constants for the coin subsystem: memory word layout, box geometry,
// screen clipping limits and the renderer state encoding.
package coin_pkg;

    localparam int unsigned NUM_COINS = 10;
    localparam int unsigned COIN_W    = 4;
    localparam int unsigned COIN_L    = 4;
    localparam int unsigned SCREEN_W  = 160;
    localparam int unsigned SCREEN_H  = 120;

    localparam int unsigned COIN_EXISTS_BIT = 15;
    localparam int unsigned COIN_X_MSB      = 14;
    localparam int unsigned COIN_X_LSB      = 7;
    localparam int unsigned COIN_Y_MSB      = 6;
    localparam int unsigned COIN_Y_LSB      = 0;

    localparam logic [2:0] COIN_COLOUR = 3'b110;
    localparam logic [2:0] BG_COLOUR   = 3'b000;

    localparam int unsigned DX_W = (COIN_W > 1) ? $clog2(COIN_W) : 1;
    localparam int unsigned DY_W = (COIN_L > 1) ? $clog2(COIN_L) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StLatch,
        StDraw,
        StDone
    } coin_state_e;

endpackage

// File: rtl/coin_box_counter.sv
// Nested pixel counter for one coin box: dx advances every enabled cycle,
// dy advances when dx wraps; last flags the final pixel of the box.
module coin_box_counter
    import coin_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            clear_i,
    input  logic            en_i,
    output logic [DX_W-1:0] dx_o,
    output logic [DY_W-1:0] dy_o,
    output logic            last_o
);

    logic [DX_W-1:0] dx_q, dx_d;
    logic [DY_W-1:0] dy_q, dy_d;
    logic            dx_wrap;
    logic            dy_wrap;

    assign dx_wrap = (dx_q == DX_W'(COIN_W - 1));
    assign dy_wrap = (dy_q == DY_W'(COIN_L - 1));

    always_comb begin
        dx_d = dx_q;
        dy_d = dy_q;
        if (clear_i) begin
            dx_d = '0;
            dy_d = '0;
        end else if (en_i) begin
            dx_d = dx_wrap ? '0 : dx_q + 1'b1;
            if (dx_wrap) begin
                dy_d = dy_wrap ? '0 : dy_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dx_q <= '0;
            dy_q <= '0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

    assign dx_o   = dx_q;
    assign dy_o   = dy_q;
    assign last_o = dx_wrap && dy_wrap;

endmodule

// File: rtl/coin_renderer.sv
// Scans the coin memory once per start pulse and plots each slot as a box,
// in the coin colour when present and in the background colour when cleared.
module coin_renderer
    import coin_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        mem_grant,
    input  logic [15:0] mem_q,
    output logic [4:0]  mem_addr,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    coin_state_e     state_q;
    logic [4:0]      slot_q;
    logic            exists_q;
    logic [7:0]      cx_q;
    logic [6:0]      cy_q;
    logic [4:0]      mem_addr_q;
    logic [7:0]      vga_x_q;
    logic [6:0]      vga_y_q;
    logic [2:0]      vga_colour_q;
    logic            plot_q;
    logic            busy_q;
    logic            done_q;

    logic [DX_W-1:0] dx;
    logic [DY_W-1:0] dy;
    logic            box_last;
    logic            box_clear;
    logic            box_en;
    logic [8:0]      sum_x;
    logic [7:0]      sum_y;

    assign box_clear = (state_q == StLatch);
    assign box_en    = (state_q == StDraw);

    coin_box_counter u_box (
        .clk_i   (clock),
        .reset_i (reset),
        .clear_i (box_clear),
        .en_i    (box_en),
        .dx_o    (dx),
        .dy_o    (dy),
        .last_o  (box_last)
    );

    // One bit wider than the coordinates so off-screen sums are not hidden by wrap.
    assign sum_x = {1'b0, cx_q} + 9'(dx);
    assign sum_y = {1'b0, cy_q} + 8'(dy);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            slot_q       <= '0;
            exists_q     <= 1'b0;
            cx_q         <= '0;
            cy_q         <= '0;
            mem_addr_q   <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            plot_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    busy_q <= start;
                    if (start) begin
                        slot_q     <= '0;
                        mem_addr_q <= '0;
                        state_q    <= StFetch;
                    end
                end
                StFetch: begin
                    if (mem_grant) state_q <= StWait;
                end
                StWait: begin
                    state_q <= StLatch;
                end
                StLatch: begin
                    exists_q <= mem_q[COIN_EXISTS_BIT];
                    cx_q     <= mem_q[COIN_X_MSB:COIN_X_LSB];
                    cy_q     <= mem_q[COIN_Y_MSB:COIN_Y_LSB];
                    state_q  <= StDraw;
                end
                StDraw: begin
                    vga_x_q      <= sum_x[7:0];
                    vga_y_q      <= sum_y[6:0];
                    vga_colour_q <= exists_q ? COIN_COLOUR : BG_COLOUR;
                    plot_q       <= (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
                    if (box_last) begin
                        if (slot_q == 5'(NUM_COINS - 1)) begin
                            state_q <= StDone;
                        end else begin
                            slot_q     <= slot_q + 5'd1;
                            mem_addr_q <= slot_q + 5'd1;
                            state_q    <= StFetch;
                        end
                    end
                end
                StDone: begin
                    // busy stays high alongside the done pulse; it drops in IDLE.
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem_addr   = mem_addr_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_coin_renderer.sv
// Bench for coin_renderer: table vectors for single-slot geometry, hand-written
// reset/stall/latch/ignored-start sequences, and random frames against a pixel-list model.
module tb_coin_renderer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        mem_grant;
    logic [15:0] mem_q;
    logic [4:0]  mem_addr;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        plot;
    logic        busy;
    logic        done;

    coin_renderer dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .mem_grant  (mem_grant),
        .mem_q      (mem_q),
        .mem_addr   (mem_addr),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Coin memory: one-cycle read latency.
    logic [15:0] mem [32];
    always @(posedge clock) mem_q <= mem[mem_addr];

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t got_q[$];
    int   got_cyc[$];
    int   done_cnt = 0;

    always @(negedge clock) begin
        if (plot) begin
            got_q.push_back({vga_x, vga_y, vga_colour});
            got_cyc.push_back(cyc);
        end
        if (done) done_cnt = done_cnt + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    int          start_cyc = 0;
    int          frame_base = 0;
    bit          frame_end = 1'b0;
    logic [15:0] snap [10];

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_start();
        start     = 1'b1;
        start_cyc = cyc + 1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Expected pixels: every on-screen pixel of every slot box, in scan order.
    task automatic run_frame(input string tag, input int exp_done);
        pix_t exp_q[$];
        int   d0, dcyc, n, bad, x, y;
        bit   seen;
        logic [15:0] w;
        for (int s = 0; s < 10; s++) snap[s] = mem[s];
        for (int s = 0; s < 10; s++) begin
            w = snap[s];
            for (int py = 0; py < 4; py++) begin
                for (int px = 0; px < 4; px++) begin
                    x = int'(w[14:7]) + px;
                    y = int'(w[6:0]) + py;
                    if (x < 160 && y < 120)
                        exp_q.push_back({8'(x), 7'(y), (w[15] ? 3'b110 : 3'b000)});
                end
            end
        end
        frame_base = got_q.size();
        d0 = done_cnt;
        pulse_start();
        seen = 1'b0;
        dcyc = 0;
        while (!seen && cyc < start_cyc + 3000) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                dcyc = cyc - start_cyc;
                check({tag, "_busy_with_done"}, int'(busy), 1);
            end
        end
        check({tag, "_done_seen"}, int'(seen), 1);
        if (exp_done >= 0) check({tag, "_done_cycle"}, dcyc, exp_done);
        @(negedge clock);
        check({tag, "_busy_after_done"}, int'(busy), 0);
        check({tag, "_done_one_cycle"}, int'(done), 0);
        repeat (20) @(negedge clock);
        check({tag, "_done_count"}, done_cnt - d0, 1);
        check({tag, "_busy_idle"}, int'(busy), 0);
        n = got_q.size() - frame_base;
        check({tag, "_plot_count"}, n, exp_q.size());
        bad = 0;
        for (int i = 0; i < n && i < exp_q.size(); i++)
            if (got_q[frame_base + i] != exp_q[i]) bad++;
        check({tag, "_pixel_errors"}, bad, 0);
        frame_end = 1'b1;
        #1;
    endtask

    typedef struct {
        logic [15:0] word;
        int slot;
        int n;
        int fx, fy, lx, ly;
        int col;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int n, bad, nst;
        tbl[0] = '{{1'b1, 8'd10,  7'd20},  0, 16, 10,  20,  13,  23,  6};
        tbl[1] = '{{1'b0, 8'd50,  7'd60},  3, 16, 50,  60,  53,  63,  0};
        tbl[2] = '{{1'b1, 8'd158, 7'd118}, 5, 4,  158, 118, 159, 119, 6};
        tbl[3] = '{{1'b1, 8'd159, 7'd0},   9, 4,  159, 0,   159, 3,   6};
        tbl[4] = '{{1'b1, 8'd0,   7'd117}, 1, 12, 0,   117, 3,   119, 6};
        tbl[5] = '{{1'b1, 8'd255, 7'd127}, 2, 0,  0,   0,   0,   0,   6};
        tbl[6] = '{{1'b0, 8'd156, 7'd116}, 7, 16, 156, 116, 159, 119, 0};

        reset = 1'b1;
        start = 1'b0;
        mem_grant = 1'b1;
        for (int s = 0; s < 32; s++) mem[s] = 16'h0000;
        repeat (3) @(posedge clock);
        #1;
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_vga_x", int'(vga_x), 0);
        check("rst_vga_y", int'(vga_y), 0);
        check("rst_colour", int'(vga_colour), 0);
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("idle_busy", int'(busy), 0);

        // Single visible slot; all others parked off-screen at x=200.
        for (int i = 0; i < 7; i++) begin
            for (int s = 0; s < 10; s++) mem[s] = 16'h6400;
            mem[tbl[i].slot] = tbl[i].word;
            run_frame($sformatf("vec%0d", i), 191);
            n = got_q.size() - frame_base;
            check($sformatf("vec%0d_count", i), n, tbl[i].n);
            if (n > 0 && tbl[i].n > 0) begin
                check($sformatf("vec%0d_first_x", i), int'(got_q[frame_base].x), tbl[i].fx);
                check($sformatf("vec%0d_first_y", i), int'(got_q[frame_base].y), tbl[i].fy);
                check($sformatf("vec%0d_last_x", i), int'(got_q[frame_base + n - 1].x), tbl[i].lx);
                check($sformatf("vec%0d_last_y", i), int'(got_q[frame_base + n - 1].y), tbl[i].ly);
                check($sformatf("vec%0d_first_cyc", i), got_cyc[frame_base] - start_cyc,
                      4 + 19 * tbl[i].slot);
                bad = 0;
                for (int k = 0; k < n; k++)
                    if (int'(got_q[frame_base + k].c) != tbl[i].col) bad++;
                check($sformatf("vec%0d_colour_errs", i), bad, 0);
            end
        end

        // Reset in the middle of slot 4's box, then a clean rescan.
        for (int s = 0; s < 10; s++) mem[s] = {1'b1, 8'(10 * s + 5), 7'(3 * s + 2)};
        pulse_start();
        wait_cyc(start_cyc + 86);
        check("mid_addr", int'(mem_addr), 4);
        check("mid_busy", int'(busy), 1);
        check("mid_plot", int'(plot), 1);
        check("mid_x", int'(vga_x), 47);
        check("mid_y", int'(vga_y), 15);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("mid_rst_plot", int'(plot), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_addr", int'(mem_addr), 0);
        check("mid_rst_x", int'(vga_x), 0);
        repeat (3) @(posedge clock);
        #1;
        check("mid_rst_stays_idle", int'(busy), 0);
        run_frame("rescan", 191);

        // start together with reset: reset wins.
        reset = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        start = 1'b0;
        check("rst_start_busy", int'(busy), 0);
        repeat (2) @(posedge clock);
        #1;
        check("rst_start_idle", int'(busy), 0);

        // Grant held low for 5 FETCH cycles of slot 2.
        nst = 0;
        fork
            run_frame("stall", 196);
            begin
                @(posedge clock);
                #1;
                while (mem_addr != 5'd2 && cyc < start_cyc + 200) @(negedge clock);
                mem_grant = 1'b0;
                repeat (5) begin
                    @(negedge clock);
                    if (plot) nst++;
                end
                check("stall_addr_held", int'(mem_addr), 2);
                mem_grant = 1'b1;
                check("stall_plots", nst, 0);
            end
        join

        // Grant drops in WAIT/LATCH; memory word rewritten during DRAW.
        fork
            run_frame("latch", 191);
            begin
                @(posedge clock);
                #1;
                wait_cyc(start_cyc + 1);
                mem_grant = 1'b0;
                wait_cyc(start_cyc + 3);
                mem_grant = 1'b1;
                wait_cyc(start_cyc + 8);
                mem[0] = mem[0] ^ 16'hffff;
            end
        join

        // start mid-scan and during DONE must both be dropped.
        fork
            run_frame("ignore", 191);
            begin
                @(posedge clock);
                #1;
                wait_cyc(start_cyc + 50);
                start = 1'b1;
                @(posedge clock);
                #1;
                start = 1'b0;
                wait_cyc(start_cyc + 190);
                start = 1'b1;
                @(posedge clock);
                #1;
                start = 1'b0;
            end
        join

        // Random memory images; later frames also randomise the grant.
        for (int f = 0; f < 4; f++) begin
            for (int s = 0; s < 10; s++) begin
                mem[s] = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                          7'($urandom_range(0, 127))};
                if ($urandom_range(0, 1) == 1)
                    mem[s][14:7] = 8'($urandom_range(150, 165));
            end
            frame_end = 1'b0;
            fork
                run_frame($sformatf("rnd%0d", f), (f == 0) ? 191 : -1);
                begin
                    if (f > 0) begin
                        while (!frame_end) begin
                            @(negedge clock);
                            mem_grant = ($urandom_range(0, 3) != 0);
                        end
                    end
                    mem_grant = 1'b1;
                end
            join
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
